// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-way cache set controller.
package cache_pkg;
  localparam int unsigned WAYS   = 4;
  localparam int unsigned AGE_W  = 2;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_UPDATE,
    ST_FETCH,
    ST_FILL,
    ST_RESP
  } state_t;
endpackage

// File: rtl/lru_victim_sel.sv
// Combinational hit/victim selection and LRU age-increment mask for one set.
module lru_victim_sel
  import cache_pkg::*;
(
  input  logic [WAYS*AGE_W-1:0] i_age,
  input  logic [WAYS-1:0]       i_empty,
  input  logic [WAYS-1:0]       i_hit,
  input  logic [IDX_W-1:0]      i_tgt_idx,
  input  logic                  i_tgt_empty,
  output logic [IDX_W-1:0]      o_hit_idx,
  output logic                  o_any_hit,
  output logic                  o_multi_hit,
  output logic [IDX_W-1:0]      o_victim_idx,
  output logic                  o_victim_empty,
  output logic [WAYS-1:0]       o_inc_mask
);
  logic [AGE_W-1:0] w_thr;

  always_comb begin
    logic found_hit;
    logic found_empty;
    logic found_old;
    logic [IDX_W-1:0] old_idx;
    o_hit_idx      = '0;
    o_victim_idx   = '0;
    o_victim_empty = 1'b0;
    o_any_hit      = |i_hit;
    o_multi_hit    = ($countones(i_hit) > 1);
    found_hit      = 1'b0;
    found_empty    = 1'b0;
    found_old      = 1'b0;
    old_idx        = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (i_hit[i] && !found_hit) begin
        o_hit_idx = IDX_W'(i);
        found_hit = 1'b1;
      end
      if (i_empty[i] && !found_empty) begin
        o_victim_idx   = IDX_W'(i);
        o_victim_empty = 1'b1;
        found_empty    = 1'b1;
      end
      if ((i_age[i*AGE_W +: AGE_W] == AGE_MAX) && !found_old) begin
        old_idx   = IDX_W'(i);
        found_old = 1'b1;
      end
    end
    if (!found_empty && found_old) o_victim_idx = old_idx;
  end

  // An empty target has no meaningful rank, so every non-saturated live way ages.
  assign w_thr = i_tgt_empty ? AGE_MAX : i_age[i_tgt_idx*AGE_W +: AGE_W];

  always_comb begin
    o_inc_mask = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      o_inc_mask[i] = !i_empty[i] && (IDX_W'(i) != i_tgt_idx) &&
                      (i_age[i*AGE_W +: AGE_W] < w_thr);
    end
  end
endmodule

// File: rtl/cache_set_ctrl.sv
// Request-side controller for one 4-way cache set: lookup, LRU update, miss fetch and fill.
module cache_set_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WAYS        = cache_pkg::WAYS,
  parameter int unsigned ADDR_W      = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W      = cache_pkg::DATA_W,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_hit,
  output logic                   resp_err,
  output logic                   line_ready,
  output logic [ADDR_W-1:0]      line_addr,
  output logic [WAYS-1:0]        line_try_read,
  output logic [WAYS-1:0]        line_try_write,
  output logic [DATA_W-1:0]      line_wdata,
  output logic [WAYS-1:0]        line_reset_age,
  output logic [WAYS-1:0]        line_inc_age,
  input  logic [WAYS*DATA_W-1:0] line_data,
  input  logic [WAYS*AGE_W-1:0]  line_age,
  input  logic [WAYS-1:0]        line_hit,
  input  logic [WAYS-1:0]        line_empty,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_write;
  logic [DATA_W-1:0]  r_data;
  logic               r_hit;
  logic               r_err;
  logic [IDX_W-1:0]   r_way;
  logic               r_victim_empty;
  logic [CNT_W-1:0]   r_cnt;

  logic [IDX_W-1:0]   w_hit_idx, w_victim_idx;
  logic               w_any_hit, w_multi_hit, w_victim_empty, w_tgt_empty;
  logic [WAYS-1:0]    w_inc_mask, w_way_oh;

  assign w_tgt_empty = (r_state == ST_FILL) && r_victim_empty;
  assign w_way_oh    = WAYS'(1) << r_way;

  lru_victim_sel u_sel (
    .i_age          (line_age),
    .i_empty        (line_empty),
    .i_hit          (line_hit),
    .i_tgt_idx      (r_way),
    .i_tgt_empty    (w_tgt_empty),
    .o_hit_idx      (w_hit_idx),
    .o_any_hit      (w_any_hit),
    .o_multi_hit    (w_multi_hit),
    .o_victim_idx   (w_victim_idx),
    .o_victim_empty (w_victim_empty),
    .o_inc_mask     (w_inc_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_write        <= 1'b0;
      r_data         <= '0;
      r_hit          <= 1'b0;
      r_err          <= 1'b0;
      r_way          <= '0;
      r_victim_empty <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_write <= req_write;
          r_data  <= req_wdata;
          r_hit   <= 1'b0;
          r_err   <= 1'b0;
        end
        ST_LOOKUP: begin
          r_hit          <= w_any_hit;
          r_err          <= w_multi_hit;
          r_way          <= w_any_hit ? w_hit_idx : w_victim_idx;
          r_victim_empty <= w_victim_empty;
          r_cnt          <= '0;
        end
        ST_UPDATE: if (!r_write) r_data <= line_data[r_way*DATA_W +: DATA_W];
        ST_FETCH: begin
          if (mem_ack) begin
            r_data <= mem_rdata;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == TO_LAST) begin
              r_err  <= 1'b1;
              r_data <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    resp_hit       = 1'b0;
    resp_err       = 1'b0;
    line_try_read  = '0;
    line_try_write = '0;
    line_wdata     = '0;
    line_reset_age = '0;
    line_inc_age   = '0;
    mem_req        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        line_try_read = '1;
        if (w_any_hit)    w_next = ST_UPDATE;
        else if (r_write) w_next = ST_FILL;
        else              w_next = ST_FETCH;
      end
      ST_UPDATE: begin
        line_reset_age = w_way_oh;
        line_inc_age   = w_inc_mask;
        if (r_write) begin
          line_try_write = w_way_oh;
          line_wdata     = r_data;
        end
        w_next = ST_RESP;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack)               w_next = ST_FILL;
        else if (r_cnt == TO_LAST) w_next = ST_RESP;
      end
      ST_FILL: begin
        line_try_write = w_way_oh;
        line_wdata     = r_data;
        line_reset_age = w_way_oh;
        line_inc_age   = w_inc_mask;
        w_next         = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_data  = r_data;
        resp_hit   = r_hit;
        resp_err   = r_err;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign line_ready = ~rst;
  assign line_addr  = r_addr;
  assign mem_addr   = r_addr;
endmodule
